cpu_cu: RTL and testbench
=========================

Name: cpu_cu

Overview:
- Multi-cycle control unit sitting directly upstream of the execution unit (EU).
- Consumes the EU's IR_out and its C/N/Z flags.
- Drives every EU control input (register addresses, ALU op, mux selects, load/increment strobes) plus the memory read/write strobes.
- Sequences fetch, decode and one execute cycle per instruction until HALT.

Parameters:
- IR_W, 16, instruction width (matches EU IR).
- RA_W, 3, register-address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- IR  in  16  instruction register contents from EU.
- C  in  1  EU carry flag.
- N  in  1  EU negative flag.
- Z  in  1  EU zero flag.
- W_Adr  out  3  register write address.
- R_Adr  out  3  register R-port address (memory address path).
- S_Adr  out  3  register S-port address.
- Alu_Op  out  4  ALU operation.
- adr_sel  out  1  1 = address from register, 0 = from PC.
- s_sel  out  1  1 = ALU S input from memory data.
- pc_ld  out  1  load PC from pc mux.
- pc_inc  out  1  increment PC.
- pc_sel  out  1  1 = PC from ALU out, 0 = PC + sext(IR[7:0]).
- reg_w_en  out  1  register file write enable.
- ir_ld  out  1  load IR from memory data.
- mr_en  out  1  memory read strobe.
- mw_en  out  1  memory write strobe, write on next clk edge.
- halted  out  1  high in HALT state.
- state  out  4  current state encoding (debug).

Behaviour:
- Reset: clk and reset, asynchronous active-high. Reset forces state=RESET; all outputs are 0 immediately.
- Control outputs are combinational from (state, IR). Only the state register is sequential.
- Memory read data is valid in the same cycle as Address and mr_en.
- Instruction fields:
  - IR[15:12] class.
  - IR[11:8] sub (ALU op or branch condition).
  - IR[5:3] rs.
  - IR[2:0] rd.
  - IR[7:0] branch offset.
- States: RESET, FETCH, DECODE, ALU, LOAD, STORE, JMP, BRA, HALT, ILLEGAL.
- RESET -> FETCH after 1 cycle.
- FETCH: adr_sel=0, mr_en=1, ir_ld=1, pc_inc=1. -> DECODE.
- DECODE: all strobes 0. Next state by class:
  - 4'h7 -> ALU
  - 4'h8 -> LOAD
  - 4'h9 -> STORE
  - 4'hB -> JMP
  - 4'hC -> BRA
  - 4'hF -> HALT
  - all other classes -> ILLEGAL
- ALU: Alu_Op=IR[11:8], R_Adr=W_Adr=rd, S_Adr=rs, s_sel=0, reg_w_en=1. -> FETCH.
- LOAD: R_Adr=rs, adr_sel=1, mr_en=1, s_sel=1, Alu_Op=ALU_PASS_S, W_Adr=rd, reg_w_en=1. -> FETCH.
- STORE: R_Adr=rd, adr_sel=1, S_Adr=rs, s_sel=0, Alu_Op=ALU_PASS_S, mw_en=1, reg_w_en=0. -> FETCH.
- JMP: S_Adr=rs, Alu_Op=ALU_PASS_S, pc_sel=1, pc_ld=1. -> FETCH.
- BRA: pc_sel=0; pc_ld=1 only if the condition holds. -> FETCH.
  - Offset is relative to the already-incremented PC.
  - Conditions (sub): 0 always, 1 C, 2 N, 3 Z, 4 !C, 5 !N, 6 !Z, 7..15 never.
  - Flags are sampled in the BRA cycle.
- HALT: sticky; halted=1, all strobes 0. Only reset exits.
- Invariants:
  - pc_ld and pc_inc never both 1.
  - mr_en and mw_en never both 1.
  - reg_w_en and mw_en never both 1.
- Reset asserted mid-instruction aborts immediately. No partial write is issued after reset assertion.
- CPI: 3 cycles for every instruction.

Optional Feature:
- Macro: CPU_CU_ILLEGAL_TRAP_EN.
- Defined: ILLEGAL is sticky with all strobes 0. Output illegal (1 bit, added port) is high; halted stays 0. Only reset exits.
- Undefined: ILLEGAL behaves as a 1-cycle NOP -> FETCH. Port illegal is absent.

Decomposition:
- Package cpu_pkg holds:
  - state encodings (RESET=0 .. ILLEGAL=9);
  - class constants CLS_ALU=4'h7, CLS_LD=4'h8, CLS_ST=4'h9, CLS_JMP=4'hB, CLS_BRA=4'hC, CLS_HALT=4'hF;
  - condition codes;
  - ALU_PASS_S=4'h0.
- One natural sub-module: cu_branch_cond. Combinational; inputs sub, C, N, Z; output take.

Test Plan:
- Reset held 3 cycles, then released -> outputs all 0 during reset; RESET then FETCH with ir_ld=pc_inc=mr_en=1 and adr_sel=0.
- IR=16'h7A1A (ALU op A, rs=3, rd=2) -> in ALU state Alu_Op=4'hA, W_Adr=R_Adr=2, S_Adr=3, reg_w_en=1; back to FETCH 3 cycles after first FETCH.
- IR=16'h8011 (LOAD rs=2, rd=1) -> R_Adr=2, adr_sel=1, s_sel=1, W_Adr=1, reg_w_en=1, mw_en=0. IR=16'h9019 (STORE rs=3, rd=1) -> R_Adr=1, S_Adr=3, mw_en=1, reg_w_en=0.
- IR=16'hC3FE with Z=1 -> pc_ld=1, pc_sel=0. Same IR with Z=0 -> pc_ld=0. IR=16'hC0xx -> always taken; IR=16'hC9xx -> never taken.
- IR=16'hF000 -> HALT with halted=1 and no strobes for 20 cycles; reset recovers to FETCH.
- IR=16'h5000 -> with CPU_CU_ILLEGAL_TRAP_EN: sticky ILLEGAL, illegal=1. Without it: FETCH follows after 1 cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared state, class and condition encodings for the cpu_cu control unit.
// Decode helper maps an instruction class to its execute state.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_ALU     = 4'd3,
    S_LOAD    = 4'd4,
    S_STORE   = 4'd5,
    S_JMP     = 4'd6,
    S_BRA     = 4'd7,
    S_HALT    = 4'd8,
    S_ILLEGAL = 4'd9
  } state_t;

  localparam logic [3:0] CLS_ALU  = 4'h7;
  localparam logic [3:0] CLS_LD   = 4'h8;
  localparam logic [3:0] CLS_ST   = 4'h9;
  localparam logic [3:0] CLS_JMP  = 4'hB;
  localparam logic [3:0] CLS_BRA  = 4'hC;
  localparam logic [3:0] CLS_HALT = 4'hF;

  localparam logic [3:0] CC_AL = 4'd0;
  localparam logic [3:0] CC_C  = 4'd1;
  localparam logic [3:0] CC_N  = 4'd2;
  localparam logic [3:0] CC_Z  = 4'd3;
  localparam logic [3:0] CC_NC = 4'd4;
  localparam logic [3:0] CC_NN = 4'd5;
  localparam logic [3:0] CC_NZ = 4'd6;

  localparam logic [3:0] ALU_PASS_S = 4'h0;

  function automatic state_t class_to_state(input logic [3:0] cls);
    state_t s;
    case (cls)
      CLS_ALU:  s = S_ALU;
      CLS_LD:   s = S_LOAD;
      CLS_ST:   s = S_STORE;
      CLS_JMP:  s = S_JMP;
      CLS_BRA:  s = S_BRA;
      CLS_HALT: s = S_HALT;
      default:  s = S_ILLEGAL;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cu_branch_cond.sv
// Branch condition evaluator: decides whether a BRA is taken
// from its condition code and the current EU flags.
module cu_branch_cond
  import cpu_pkg::*;
(
  input  logic [3:0] sub,
  input  logic       C,
  input  logic       N,
  input  logic       Z,
  output logic       take
);

  // condition table; codes 7..15 are never taken
  always_comb begin
    take = 1'b0;
    case (sub)
      CC_AL:   take = 1'b1;
      CC_C:    take = C;
      CC_N:    take = N;
      CC_Z:    take = Z;
      CC_NC:   take = ~C;
      CC_NN:   take = ~N;
      CC_NZ:   take = ~Z;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_cu.sv
// Multi-cycle control unit: fetch, decode, one execute cycle per instruction.
// CPU_CU_ILLEGAL_TRAP_EN makes ILLEGAL a sticky trap with an illegal port.
module cpu_cu
  import cpu_pkg::*;
#(
  parameter int IR_W = 16,
  parameter int RA_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IR_W-1:0] IR,
  input  logic            C,
  input  logic            N,
  input  logic            Z,
  output logic [RA_W-1:0] W_Adr,
  output logic [RA_W-1:0] R_Adr,
  output logic [RA_W-1:0] S_Adr,
  output logic [3:0]      Alu_Op,
  output logic            adr_sel,
  output logic            s_sel,
  output logic            pc_ld,
  output logic            pc_inc,
  output logic            pc_sel,
  output logic            reg_w_en,
  output logic            ir_ld,
  output logic            mr_en,
  output logic            mw_en,
  output logic            halted,
`ifdef CPU_CU_ILLEGAL_TRAP_EN
  output logic            illegal,
`endif
  output logic [3:0]      state
);

  state_t cs, ns;

  logic [3:0]      cls;
  logic [3:0]      sub;
  logic [RA_W-1:0] rs;
  logic [RA_W-1:0] rd;
  logic            take;
  logic            unused_ir;

  assign cls = IR[15:12];
  assign sub = IR[11:8];
  assign rs  = IR[5:3];
  assign rd  = IR[2:0];
  // offset bits feed the EU adder directly, not this unit
  assign unused_ir = ^IR[7:6];

  assign state = cs;

  cu_branch_cond u_cond (
    .sub  (sub),
    .C    (C),
    .N    (N),
    .Z    (Z),
    .take (take)
  );

  // state register; reset aborts any instruction at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cs <= S_RESET;
    else       cs <= ns;
  end

  // next-state and control decode from state and IR
  always_comb begin
    ns       = cs;
    W_Adr    = '0;
    R_Adr    = '0;
    S_Adr    = '0;
    Alu_Op   = ALU_PASS_S;
    adr_sel  = 1'b0;
    s_sel    = 1'b0;
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;
    pc_sel   = 1'b0;
    reg_w_en = 1'b0;
    ir_ld    = 1'b0;
    mr_en    = 1'b0;
    mw_en    = 1'b0;
    halted   = 1'b0;
    case (cs)
      S_RESET: ns = S_FETCH;
      S_FETCH: begin
        mr_en  = 1'b1;
        ir_ld  = 1'b1;
        pc_inc = 1'b1;
        ns     = S_DECODE;
      end
      S_DECODE: ns = class_to_state(cls);
      S_ALU: begin
        Alu_Op   = sub;
        R_Adr    = rd;
        W_Adr    = rd;
        S_Adr    = rs;
        reg_w_en = 1'b1;
        ns       = S_FETCH;
      end
      S_LOAD: begin
        R_Adr    = rs;
        adr_sel  = 1'b1;
        mr_en    = 1'b1;
        s_sel    = 1'b1;
        W_Adr    = rd;
        reg_w_en = 1'b1;
        ns       = S_FETCH;
      end
      S_STORE: begin
        R_Adr   = rd;
        S_Adr   = rs;
        adr_sel = 1'b1;
        mw_en   = 1'b1;
        ns      = S_FETCH;
      end
      S_JMP: begin
        S_Adr  = rs;
        pc_sel = 1'b1;
        pc_ld  = 1'b1;
        ns     = S_FETCH;
      end
      S_BRA: begin
        pc_ld = take;
        ns    = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        ns     = S_HALT;
      end
      S_ILLEGAL: begin
`ifdef CPU_CU_ILLEGAL_TRAP_EN
        ns = S_ILLEGAL;
`else
        ns = S_FETCH;
`endif
      end
      default: ns = S_RESET;
    endcase
  end

`ifdef CPU_CU_ILLEGAL_TRAP_EN
  assign illegal = (cs == S_ILLEGAL);
`endif

endmodule

// File: tb/tb_cpu_cu.sv
// Scoreboard bench for cpu_cu: expected execute-cycle controls are
// queued when an instruction is presented and popped when it executes.
module tb_cpu_cu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] IR = '0;
  logic        C = 1'b0;
  logic        N = 1'b0;
  logic        Z = 1'b0;
  logic [2:0]  W_Adr, R_Adr, S_Adr;
  logic [3:0]  Alu_Op, state;
  logic        adr_sel, s_sel, pc_ld, pc_inc, pc_sel;
  logic        reg_w_en, ir_ld, mr_en, mw_en, halted;
`ifdef CPU_CU_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  int checks = 0;
  int errors = 0;
  logic [26:0] sb[$];

  localparam logic [9:0] ADR = 10'b10_0000_0000;
  localparam logic [9:0] SSL = 10'b01_0000_0000;
  localparam logic [9:0] PLD = 10'b00_1000_0000;
  localparam logic [9:0] PIN = 10'b00_0100_0000;
  localparam logic [9:0] PSL = 10'b00_0010_0000;
  localparam logic [9:0] RWE = 10'b00_0001_0000;
  localparam logic [9:0] IRL = 10'b00_0000_1000;
  localparam logic [9:0] MRE = 10'b00_0000_0100;
  localparam logic [9:0] MWE = 10'b00_0000_0010;
  localparam logic [9:0] HLT = 10'b00_0000_0001;

  cpu_cu dut (
    .clk      (clk),
    .reset    (reset),
    .IR       (IR),
    .C        (C),
    .N        (N),
    .Z        (Z),
    .W_Adr    (W_Adr),
    .R_Adr    (R_Adr),
    .S_Adr    (S_Adr),
    .Alu_Op   (Alu_Op),
    .adr_sel  (adr_sel),
    .s_sel    (s_sel),
    .pc_ld    (pc_ld),
    .pc_inc   (pc_inc),
    .pc_sel   (pc_sel),
    .reg_w_en (reg_w_en),
    .ir_ld    (ir_ld),
    .mr_en    (mr_en),
    .mw_en    (mw_en),
    .halted   (halted),
`ifdef CPU_CU_ILLEGAL_TRAP_EN
    .illegal  (illegal),
`endif
    .state    (state)
  );

  always #5 clk = ~clk;

  function automatic logic [26:0] mk(input logic [3:0] st,
                                     input logic [2:0] w,
                                     input logic [2:0] r,
                                     input logic [2:0] s,
                                     input logic [3:0] op,
                                     input logic [9:0] str);
    return {st, w, r, s, op, str};
  endfunction

  function automatic logic [26:0] obs();
    return {state, W_Adr, R_Adr, S_Adr, Alu_Op,
            adr_sel, s_sel, pc_ld, pc_inc, pc_sel,
            reg_w_en, ir_ld, mr_en, mw_en, halted};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // async reset, held 3 cycles, released; ends at the first FETCH negedge
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1 check({tag, ":async"}, 32'(obs()), 32'(mk(0, 0, 0, 0, 0, 0)));
    repeat (3) begin
      @(negedge clk);
      check({tag, ":held"}, 32'(obs()), 32'(mk(0, 0, 0, 0, 0, 0)));
    end
    reset = 1'b0;
    #1 check({tag, ":rel"}, 32'(obs()), 32'(mk(0, 0, 0, 0, 0, 0)));
    @(negedge clk);
  endtask

  // present one instruction at FETCH and check it through execute
  task automatic run_instr(input string tag, input logic [15:0] ir,
                           input logic c, input logic n,
                           input logic z, input logic [26:0] exe);
    logic [26:0] e;
    check({tag, ":fetch"}, 32'(obs()),
          32'(mk(1, 0, 0, 0, 0, PIN | IRL | MRE)));
    IR = ir;
    C  = c;
    N  = n;
    Z  = z;
    sb.push_back(exe);
    @(negedge clk);
    check({tag, ":decode"}, 32'(obs()), 32'(mk(2, 0, 0, 0, 0, 0)));
    @(negedge clk);
    e = sb.pop_front();
    check(tag, 32'(obs()), 32'(e));
    check({tag, ":inv"},
          {29'd0, pc_ld & pc_inc, mr_en & mw_en, reg_w_en & mw_en},
          32'd0);
    @(negedge clk);
  endtask

  initial begin
    do_reset("rst0");

    run_instr("alu", 16'h7A1A, 0, 0, 0, mk(3, 2, 2, 3, 4'hA, RWE));
    run_instr("load", 16'h8011, 0, 0, 0,
              mk(4, 1, 2, 0, 0, ADR | SSL | MRE | RWE));
    run_instr("store", 16'h9019, 0, 0, 0, mk(5, 0, 1, 3, 0, ADR | MWE));
    run_instr("jmp", 16'hB028, 0, 0, 0, mk(6, 0, 0, 5, 0, PSL | PLD));
    run_instr("bz_t", 16'hC3FE, 0, 0, 1, mk(7, 0, 0, 0, 0, PLD));
    run_instr("bz_n", 16'hC3FE, 1, 1, 0, mk(7, 0, 0, 0, 0, 0));
    run_instr("bal", 16'hC012, 0, 0, 0, mk(7, 0, 0, 0, 0, PLD));
    run_instr("bnv", 16'hC9FF, 1, 1, 1, mk(7, 0, 0, 0, 0, 0));
    run_instr("bc", 16'hC104, 1, 0, 0, mk(7, 0, 0, 0, 0, PLD));
    run_instr("bn", 16'hC204, 0, 1, 0, mk(7, 0, 0, 0, 0, PLD));
    run_instr("bnc", 16'hC404, 1, 0, 0, mk(7, 0, 0, 0, 0, 0));
    run_instr("bnn", 16'hC504, 1, 0, 1, mk(7, 0, 0, 0, 0, PLD));
    run_instr("bnz", 16'hC604, 0, 0, 1, mk(7, 0, 0, 0, 0, 0));
    run_instr("bnz_t", 16'hC604, 1, 1, 0, mk(7, 0, 0, 0, 0, PLD));

    // reset during a store must kill the write strobe immediately
    check("ab:fetch", 32'(obs()), 32'(mk(1, 0, 0, 0, 0, PIN | IRL | MRE)));
    IR = 16'h9019;
    @(negedge clk);
    @(negedge clk);
    check("ab:mw", {31'd0, mw_en}, 32'd1);
    do_reset("abort");

    run_instr("ill", 16'h5000, 0, 0, 0, mk(9, 0, 0, 0, 0, 0));
`ifdef CPU_CU_ILLEGAL_TRAP_EN
    for (int i = 0; i < 5; i++) begin
      check("ill:stick", 32'(obs()), 32'(mk(9, 0, 0, 0, 0, 0)));
      check("ill:flag", {31'd0, illegal}, 32'd1);
      @(negedge clk);
    end
    do_reset("rst_ill");
`endif
    run_instr("alu2", 16'h7315, 0, 0, 0, mk(3, 5, 5, 2, 4'h3, RWE));

    run_instr("halt", 16'hF000, 0, 0, 0, mk(8, 0, 0, 0, 0, HLT));
    for (int i = 0; i < 20; i++) begin
      check("halt:stick", 32'(obs()), 32'(mk(8, 0, 0, 0, 0, HLT)));
      @(negedge clk);
    end
    do_reset("rst_halt");
    run_instr("post", 16'h7A1A, 0, 0, 0, mk(3, 2, 2, 3, 4'hA, RWE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
